// File: rtl/adc_sample_conditioner.sv
// ADC sample conditioner: zero-offset removal, power-of-two moving average,
// over-current flag and a zero-offset calibration state machine.
module adc_sample_conditioner #(
  parameter int                 AVG_SHIFT = 2,
  parameter int                 CAL_SHIFT = 8,
  parameter logic signed [16:0] OC_LIMIT  = 17'sd60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               adc_valid,
  input  logic signed [15:0] adc_cur_raw,
  input  logic signed [15:0] adc_vol_raw,
  input  logic               is_machine_start,
  input  logic               cal_start,
  output logic signed [16:0] sample_current,
  output logic signed [16:0] sample_voltage,
  output logic               sample_valid,
  output logic               over_current,
  output logic signed [15:0] offset_cur,
  output logic signed [15:0] offset_vol,
  output logic               cal_busy,
  output logic               cal_done,
  output logic               cal_abort
);

  localparam int SW = 17 + AVG_SHIFT;
  localparam int PW = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;
  localparam int RN = 1 << PW;
  localparam int AW = 16 + CAL_SHIFT;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_COMMIT
  } state_t;

  state_t                 r_state;
  logic signed [AW-1:0]   r_acc_cur;
  logic signed [AW-1:0]   r_acc_vol;
  logic [CAL_SHIFT-1:0]   r_cnt;

  logic                   r_s1_valid;
  logic signed [16:0]     r_diff_cur;
  logic signed [16:0]     r_diff_vol;

  logic signed [16:0]     r_ring_cur [RN];
  logic signed [16:0]     r_ring_vol [RN];
  logic signed [SW-1:0]   r_sum_cur;
  logic signed [SW-1:0]   r_sum_vol;
  logic [PW-1:0]          r_wptr;

  logic                   w_flush;
  logic signed [SW-1:0]   w_sum_cur_nxt;
  logic signed [SW-1:0]   w_sum_vol_nxt;
  logic signed [16:0]     w_avg_cur;
  logic signed [16:0]     w_avg_vol;
  logic [PW-1:0]          w_wptr_nxt;

  assign w_flush = (r_state == S_COMMIT);

  // With W=1 the single ring slot always equals the running sum, so the
  // update degenerates to sum = diff and the filter is bypassed.
  assign w_sum_cur_nxt = r_sum_cur + SW'(r_diff_cur)
                       - SW'(r_ring_cur[r_wptr]);
  assign w_sum_vol_nxt = r_sum_vol + SW'(r_diff_vol)
                       - SW'(r_ring_vol[r_wptr]);

  assign w_avg_cur = 17'(w_sum_cur_nxt >>> AVG_SHIFT);
  assign w_avg_vol = 17'(w_sum_vol_nxt >>> AVG_SHIFT);

  assign w_wptr_nxt = (AVG_SHIFT == 0) ? '0 : r_wptr + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_diff_cur <= '0;
      r_diff_vol <= '0;
    end else begin
      r_s1_valid <= adc_valid;
      if (adc_valid) begin
        r_diff_cur <= 17'(adc_cur_raw) - 17'(offset_cur);
        r_diff_vol <= 17'(adc_vol_raw) - 17'(offset_vol);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < RN; k++) begin
        r_ring_cur[k] <= '0;
        r_ring_vol[k] <= '0;
      end
      r_sum_cur      <= '0;
      r_sum_vol      <= '0;
      r_wptr         <= '0;
      sample_current <= '0;
      sample_voltage <= '0;
      sample_valid   <= 1'b0;
      over_current   <= 1'b0;
    end else if (w_flush) begin
      for (int k = 0; k < RN; k++) begin
        r_ring_cur[k] <= '0;
        r_ring_vol[k] <= '0;
      end
      r_sum_cur    <= '0;
      r_sum_vol    <= '0;
      r_wptr       <= '0;
      sample_valid <= 1'b0;
    end else if (r_s1_valid) begin
      r_ring_cur[r_wptr] <= r_diff_cur;
      r_ring_vol[r_wptr] <= r_diff_vol;
      r_sum_cur      <= w_sum_cur_nxt;
      r_sum_vol      <= w_sum_vol_nxt;
      r_wptr         <= w_wptr_nxt;
      sample_current <= w_avg_cur;
      sample_voltage <= w_avg_vol;
      sample_valid   <= 1'b1;
      over_current   <= (w_avg_cur > OC_LIMIT);
    end else begin
      sample_valid <= 1'b0;
    end
  end

  // Calibration averages raw codes, so the result is independent of the
  // offsets currently in use by the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_acc_cur  <= '0;
      r_acc_vol  <= '0;
      r_cnt      <= '0;
      offset_cur <= '0;
      offset_vol <= '0;
      cal_busy   <= 1'b0;
      cal_done   <= 1'b0;
      cal_abort  <= 1'b0;
    end else begin
      cal_done  <= 1'b0;
      cal_abort <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cal_start && !is_machine_start) begin
            r_state   <= S_ACCUM;
            r_acc_cur <= '0;
            r_acc_vol <= '0;
            r_cnt     <= '0;
            cal_busy  <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (is_machine_start) begin
            r_state   <= S_IDLE;
            cal_busy  <= 1'b0;
            cal_abort <= 1'b1;
          end else if (adc_valid) begin
            r_acc_cur <= r_acc_cur + AW'(adc_cur_raw);
            r_acc_vol <= r_acc_vol + AW'(adc_vol_raw);
            r_cnt     <= r_cnt + CAL_SHIFT'(1);
            if (r_cnt == '1) begin
              r_state <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          offset_cur <= 16'(r_acc_cur >>> CAL_SHIFT);
          offset_vol <= 16'(r_acc_vol >>> CAL_SHIFT);
          cal_busy   <= 1'b0;
          cal_done   <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          cal_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Bench for adc_sample_conditioner: two instances (W=4/CAL=256 and
// bypass W=1/CAL=4) checked every cycle against a window-average model.
module tb_adc_sample_conditioner;

  localparam int OC = 60;
  localparam int M_IDLE   = 0;
  localparam int M_ACCUM  = 1;
  localparam int M_COMMIT = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               adc_valid;
  logic signed [15:0] cur_raw;
  logic signed [15:0] vol_raw;
  logic               ims;
  logic               cal_s;

  logic signed [16:0] sc   [2];
  logic signed [16:0] sv   [2];
  logic               val  [2];
  logic               oc   [2];
  logic signed [15:0] ofc  [2];
  logic signed [15:0] ofv  [2];
  logic               busy [2];
  logic               done [2];
  logic               abrt [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  adc_sample_conditioner u_a (
    .clk(clk), .rst(rst), .adc_valid(adc_valid),
    .adc_cur_raw(cur_raw), .adc_vol_raw(vol_raw),
    .is_machine_start(ims), .cal_start(cal_s),
    .sample_current(sc[0]), .sample_voltage(sv[0]),
    .sample_valid(val[0]), .over_current(oc[0]),
    .offset_cur(ofc[0]), .offset_vol(ofv[0]),
    .cal_busy(busy[0]), .cal_done(done[0]), .cal_abort(abrt[0])
  );

  adc_sample_conditioner #(
    .AVG_SHIFT(0), .CAL_SHIFT(2), .OC_LIMIT(17'sd60)
  ) u_b (
    .clk(clk), .rst(rst), .adc_valid(adc_valid),
    .adc_cur_raw(cur_raw), .adc_vol_raw(vol_raw),
    .is_machine_start(ims), .cal_start(cal_s),
    .sample_current(sc[1]), .sample_voltage(sv[1]),
    .sample_valid(val[1]), .over_current(oc[1]),
    .offset_cur(ofc[1]), .offset_vol(ofv[1]),
    .cal_busy(busy[1]), .cal_done(done[1]), .cal_abort(abrt[1])
  );

  // ---------------- reference model ----------------
  int      st    [2];
  longint  acc_c [2];
  longint  acc_v [2];
  int      cnt   [2];
  int      off_c [2];
  int      off_v [2];
  bit      p_ok  [2];
  int      p_c   [2];
  int      p_v   [2];
  int      hc    [2][16];
  int      hv    [2][16];
  int      e_sc  [2];
  int      e_sv  [2];
  bit      e_val [2];
  bit      e_oc  [2];
  bit      e_busy[2];
  bit      e_done[2];
  bit      e_abt [2];

  function automatic int avg_shift_of(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int cal_shift_of(int i);
    return (i == 0) ? 8 : 2;
  endfunction

  function automatic longint fdiv(longint a, longint n);
    longint q;
    q = a / n;
    if ((a % n != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      st[i] = M_IDLE; acc_c[i] = 0; acc_v[i] = 0; cnt[i] = 0;
      off_c[i] = 0; off_v[i] = 0; p_ok[i] = 0; p_c[i] = 0; p_v[i] = 0;
      for (int k = 0; k < 16; k++) begin
        hc[i][k] = 0; hv[i][k] = 0;
      end
      e_sc[i] = 0; e_sv[i] = 0; e_val[i] = 0; e_oc[i] = 0;
      e_busy[i] = 0; e_done[i] = 0; e_abt[i] = 0;
    end
  endtask

  task automatic step(int i);
    int w, n, s_c, s_v;
    bit fl;
    w = 1 << avg_shift_of(i);
    n = 1 << cal_shift_of(i);
    fl = (st[i] == M_COMMIT);
    e_done[i] = 0; e_abt[i] = 0; e_val[i] = 0;
    if (fl) begin
      for (int k = 0; k < 16; k++) begin
        hc[i][k] = 0; hv[i][k] = 0;
      end
    end else if (p_ok[i]) begin
      for (int k = 15; k > 0; k--) begin
        hc[i][k] = hc[i][k-1]; hv[i][k] = hv[i][k-1];
      end
      hc[i][0] = p_c[i]; hv[i][0] = p_v[i];
      s_c = 0; s_v = 0;
      for (int k = 0; k < w; k++) begin
        s_c += hc[i][k]; s_v += hv[i][k];
      end
      e_sc[i]  = int'(fdiv(s_c, w));
      e_sv[i]  = int'(fdiv(s_v, w));
      e_val[i] = 1;
      e_oc[i]  = (e_sc[i] > OC);
    end
    p_ok[i] = adc_valid;
    if (adc_valid) begin
      p_c[i] = int'(cur_raw) - off_c[i];
      p_v[i] = int'(vol_raw) - off_v[i];
    end
    case (st[i])
      M_IDLE: begin
        if (cal_s && !ims) begin
          st[i] = M_ACCUM; acc_c[i] = 0; acc_v[i] = 0; cnt[i] = 0;
          e_busy[i] = 1;
        end
      end
      M_ACCUM: begin
        if (ims) begin
          st[i] = M_IDLE; e_abt[i] = 1; e_busy[i] = 0;
        end else if (adc_valid) begin
          acc_c[i] += int'(cur_raw);
          acc_v[i] += int'(vol_raw);
          cnt[i]++;
          if (cnt[i] == n) st[i] = M_COMMIT;
        end
      end
      default: begin
        off_c[i] = int'(fdiv(acc_c[i], n));
        off_v[i] = int'(fdiv(acc_v[i], n));
        st[i] = M_IDLE; e_done[i] = 1; e_busy[i] = 0;
      end
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      step(0);
      step(1);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  function automatic void chk(int i, string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL u%0d.%s at cycle %0d: got %0d expected %0d",
               i, nm, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk(i, "sample_current", int'(sc[i]), e_sc[i]);
      chk(i, "sample_voltage", int'(sv[i]), e_sv[i]);
      chk(i, "sample_valid", int'(val[i]), int'(e_val[i]));
      chk(i, "over_current", int'(oc[i]), int'(e_oc[i]));
      chk(i, "offset_cur", int'(ofc[i]), off_c[i]);
      chk(i, "offset_vol", int'(ofv[i]), off_v[i]);
      chk(i, "cal_busy", int'(busy[i]), int'(e_busy[i]));
      chk(i, "cal_done", int'(done[i]), int'(e_done[i]));
      chk(i, "cal_abort", int'(abrt[i]), int'(e_abt[i]));
    end
  end

  // ---------------- capture for literal checks ----------------
  bit cap_en = 0;
  int n_val [2];
  int n_done[2];
  int n_abt [2];
  int qc0[$];
  int qv0[$];
  int qo0[$];
  int qc1[$];
  int qt1[$];

  task automatic cap_clear();
    for (int i = 0; i < 2; i++) begin
      n_val[i] = 0; n_done[i] = 0; n_abt[i] = 0;
    end
    qc0.delete(); qv0.delete(); qo0.delete(); qc1.delete(); qt1.delete();
  endtask

  task automatic cap_sample();
    for (int i = 0; i < 2; i++) begin
      if (val[i]) n_val[i]++;
      if (done[i]) n_done[i]++;
      if (abrt[i]) n_abt[i]++;
    end
    if (val[0]) begin
      qc0.push_back(int'(sc[0]));
      qv0.push_back(int'(sv[0]));
      qo0.push_back(int'(oc[0]));
    end
    if (val[1]) begin
      qc1.push_back(int'(sc[1]));
      qt1.push_back(cyc);
    end
  endtask

  always @(negedge clk) if (cap_en) cap_sample();

  // ---------------- stimulus ----------------
  task automatic drv(bit v, int c, int vo, bit m, bit cs);
    adc_valid = v;
    cur_raw   = 16'(c);
    vol_raw   = 16'(vo);
    ims       = m;
    cal_s     = cs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n, bit m);
    for (int k = 0; k < n; k++) drv(0, 0, 0, m, 0);
  endtask

  int ramp_c[4] = '{7, 15, 22, 30};
  int ramp_v[4] = '{30, 60, 90, 120};
  int oc_c[8]   = '{20, 40, 60, 80, 60, 40, 20, 0};
  int oc_f[8]   = '{0, 0, 0, 1, 0, 0, 0, 0};

  initial begin
    bit rv, rcs, rims;
    int rc, rvo;
    rst = 1'b1;
    adc_valid = 0; cur_raw = '0; vol_raw = '0; ims = 0; cal_s = 0;

    // reset with adc_valid toggling
    for (int k = 0; k < 5; k++) drv(k[0], 123, -5, 0, 0);
    chk(0, "reset_valid", int'(val[0]), 0);
    chk(0, "reset_offset", int'(ofc[0]), 0);
    rst = 1'b0;
    idle(3, 0);

    // calibration to 100/-40, last strobe collides with COMMIT
    cap_clear(); cap_en = 1;
    drv(0, 0, 0, 0, 1);
    for (int k = 0; k < 256; k++) begin
      drv(1, 100, -40, 0, 0);
      if (k == 100) chk(0, "busy_mid_cal", int'(busy[0]), 1);
    end
    idle(4, 0);
    cap_en = 0;
    chk(0, "cal_valid_count", n_val[0], 255);
    chk(0, "cal_done_count", n_done[0], 1);
    chk(0, "cal_offset_cur", int'(ofc[0]), 100);
    chk(0, "cal_offset_vol", int'(ofv[0]), -40);

    // ramp after flush
    cap_clear(); cap_en = 1;
    for (int k = 0; k < 4; k++) drv(1, 130, 80, 0, 0);
    idle(3, 0);
    cap_en = 0;
    chk(0, "ramp_count", qc0.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk(0, "ramp_cur", (k < qc0.size()) ? qc0[k] : -999999, ramp_c[k]);
      chk(0, "ramp_vol", (k < qv0.size()) ? qv0[k] : -999999, ramp_v[k]);
    end

    // abort
    cap_clear(); cap_en = 1;
    drv(0, 0, 0, 0, 1);
    for (int k = 0; k < 50; k++) drv(1, 7, 9, 0, 0);
    idle(3, 1);
    cap_en = 0;
    chk(0, "abort_count", n_abt[0], 1);
    chk(0, "abort_offset_cur", int'(ofc[0]), 100);
    chk(0, "abort_offset_vol", int'(ofv[0]), -40);
    chk(0, "abort_busy", int'(busy[0]), 0);
    chk(1, "short_cal_offset", int'(ofc[1]), 7);
    cap_clear(); cap_en = 1;
    drv(0, 0, 0, 1, 1);
    idle(3, 1);
    cap_en = 0;
    chk(0, "blocked_busy", int'(busy[0]), 0);
    chk(0, "blocked_pulses", n_done[0] + n_abt[0], 0);

    // full throughput, extreme codes through the bypass instance
    drv(0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) drv(1, 32767, 0, 0, 0);
    idle(2, 0);
    drv(0, 0, 0, 1, 0);
    chk(1, "max_offset", int'(ofc[1]), 32767);
    cap_clear(); cap_en = 1;
    for (int k = 0; k < 20; k++) drv(1, -32768, 0, 1, 0);
    idle(3, 1);
    cap_en = 0;
    chk(1, "burst_count", n_val[1], 20);
    chk(1, "burst_span",
        (qt1.size() == 20) ? qt1[19] - qt1[0] : -1, 19);
    chk(1, "burst_min_first", (qc1.size() > 0) ? qc1[0] : 0, -65535);
    chk(1, "burst_min_last", (qc1.size() == 20) ? qc1[19] : 0, -65535);

    // over-current with zero offset
    drv(0, 0, 0, 0, 1);
    for (int k = 0; k < 256; k++) drv(1, 0, 0, 0, 0);
    idle(3, 0);
    chk(0, "zero_offset", int'(ofc[0]), 0);
    cap_clear(); cap_en = 1;
    for (int k = 0; k < 4; k++) drv(1, 80, 0, 0, 0);
    for (int k = 0; k < 4; k++) drv(1, 0, 0, 0, 0);
    idle(3, 0);
    cap_en = 0;
    chk(0, "oc_count", qc0.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk(0, "oc_cur", (k < qc0.size()) ? qc0[k] : -999999, oc_c[k]);
      chk(0, "oc_flag", (k < qo0.size()) ? qo0[k] : -1, oc_f[k]);
    end

    // randomized traffic with a mid-run reset
    rims = 0;
    for (int k = 0; k < 4000; k++) begin
      if (k == 2000) begin
        rst = 1'b1;
        idle(2, rims);
        rst = 1'b0;
      end
      if ($urandom_range(0, 299) == 0) rims = ~rims;
      rv  = ($urandom_range(0, 3) != 0);
      rcs = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 1) == 1) begin
        rc  = int'($urandom_range(0, 65535)) - 32768;
        rvo = int'($urandom_range(0, 65535)) - 32768;
      end else begin
        rc  = int'($urandom_range(0, 300)) - 150;
        rvo = int'($urandom_range(0, 300)) - 150;
      end
      drv(rv, rc, rvo, rims, rcs);
    end
    idle(4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_sample_conditioner.md
Name: adc_sample_conditioner

Overview:
- Conditions the raw gap current and gap voltage ADC codes before they reach the pulse/MOSFET control stage.
- Per sample: removes the calibrated zero offset and applies a power-of-two moving-average filter.
- Outputs signed 17-bit sample_current and sample_voltage plus an over-current flag.
- Contains a zero-offset calibration state machine. Calibration is permitted only while the machine is stopped.

Parameters:
- AVG_SHIFT, 2: log2 of the moving-average window length (window W = 2^AVG_SHIFT, legal range 0..4).
- CAL_SHIFT, 8: log2 of the number of samples averaged during calibration (legal range 1..12).
- OC_LIMIT, 17'sd60: over-current threshold on the filtered current, signed, non-negative.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- adc_valid  in  1  one-cycle strobe; both raw channels are valid this cycle
- adc_cur_raw  in  16  current ADC code, two's complement
- adc_vol_raw  in  16  voltage ADC code, two's complement
- is_machine_start  in  1  machining enabled; blocks or aborts calibration
- cal_start  in  1  one-cycle calibration request
- sample_current  out  17  filtered, offset-corrected current, signed
- sample_voltage  out  17  filtered, offset-corrected voltage, signed
- sample_valid  out  1  one-cycle strobe; new sample_* values are present
- over_current  out  1  sample_current > OC_LIMIT; updated with sample_valid
- offset_cur  out  16  current calibrated offset, signed
- offset_vol  out  16  voltage calibrated offset, signed
- cal_busy  out  1  high while calibration is accumulating
- cal_done  out  1  one-cycle pulse when new offsets are committed
- cal_abort  out  1  one-cycle pulse when calibration is aborted

Behaviour:
- Reset, asynchronous with rst high:
  - all outputs 0
  - offsets 0
  - ring buffers and running sums 0
  - FSM in IDLE
- Datapath stage 1, on the cycle after adc_valid:
  - diff_x = sext17(raw_x) - sext17(offset_x)
  - The full range -65535..65535 fits in 17 bits, so no saturation is applied.
- Datapath stage 2, one cycle later:
  - sum_x (width 17+AVG_SHIFT) = sum_x + diff_x - ring_x[wptr]
  - ring_x[wptr] <= diff_x
  - wptr increments modulo W
  - sample_x <= (next sum_x) >>> AVG_SHIFT, arithmetic shift, truncating toward negative infinity
- Latency and throughput:
  - sample_valid and over_current are registered 2 cycles after adc_valid.
  - adc_valid may be asserted on every cycle, giving full throughput with no stalls.
- Warm-up: the ring starts at zero. The first W-1 outputs after a reset or flush are diluted by zeros, by design.
- AVG_SHIFT = 0: the filter is bypassed (sample = diff) with the same 2-cycle latency.
- Outputs hold their values between sample_valid strobes.
- FSM states: IDLE, ACCUM, COMMIT.
  - IDLE -> ACCUM: when cal_start=1 and is_machine_start=0. On entry, acc_cur, acc_vol and cnt are cleared and cal_busy is raised.
  - IDLE with cal_start while is_machine_start=1: the request is ignored and no pulse is generated.
  - ACCUM, on each adc_valid: acc_x += sext(raw_x) using the raw code, not the corrected value; cnt increments.
  - ACCUM -> COMMIT: when the 2^CAL_SHIFT-th sample is accumulated.
  - ACCUM abort: is_machine_start=1 at any cycle in ACCUM returns the FSM to IDLE with offsets unchanged. cal_abort pulses and cal_busy drops.
  - cal_start received during ACCUM or COMMIT is ignored.
  - COMMIT, one cycle:
    - offset_x <= acc_x >>> CAL_SHIFT
    - ring buffers, sums and wptr are cleared
    - cal_done pulses, cal_busy drops, then the FSM returns to IDLE
- During ACCUM the datapath keeps running with the old offsets.
- Simultaneous events:
  - A flush in COMMIT takes priority over a stage-2 update in the same cycle. That sample is discarded and no sample_valid is issued for it.
  - Samples already in stage 1 at COMMIT use the old offset and enter the cleared ring.
- over_current: non-sticky, a pure function of each new sample_current. The comparison is signed.

Test Plan:
1. Reset check: hold rst for 5 cycles with adc_valid toggling -> all outputs 0 throughout; no sample_valid while rst is high.
2. Calibration with CAL_SHIFT=8: is_machine_start=0, cal_start pulse, then 256 strobes of cur=100, vol=-40 -> cal_busy is high for the full accumulation; one cal_done pulse; offset_cur=100, offset_vol=-40. Then feed cur=130, vol=80 for 4 strobes -> sample_current ramps 7, 15, 22, 30 and sample_voltage ramps 30, 60, 90, 120, each 2 cycles after its adc_valid.
3. Abort: start calibration, raise is_machine_start after 50 strobes -> cal_abort pulse; offsets unchanged at their prior values; FSM in IDLE. A subsequent cal_start while is_machine_start=1 -> no response.
4. Throughput and extremes: adc_valid held high for 20 cycles, offset_cur=32767, raw_cur=-32768, AVG_SHIFT=0 -> sample_valid on 20 consecutive cycles; sample_current=-65535.
5. Over-current: offset 0, raw_cur steps 0 -> 80 with W=4 -> sample_current goes 20, 40, 60, 80; over_current asserts only on the 4th strobe. Raw_cur then returns to 0 -> over_current clears once the average falls to 60 or below.
6. Flush collision: adc_valid arrives 1 cycle before COMMIT -> that sample is dropped with no sample_valid; the next sample's output equals (raw - new_offset) >>> AVG_SHIFT.
